// File: rtl/burst_stream_tx_pkg.sv
// Shared definitions for the burst stream transmitter: default sample width and FSM states.
package burst_stream_tx_pkg;

   localparam int DEF_DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BURST = 2'd1,
      GAP   = 2'd2
   } state_t;

endpackage

// File: rtl/burst_stream_tx_sync_fifo.sv
// Single-clock FIFO with combinational head read; pointers carry one extra wrap bit so
// level = wr_ptr - rd_ptr distinguishes full from empty.
module sync_fifo
   import burst_stream_tx_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH  = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wr_en,
   input  logic [DATA_W-1:0]        wr_dat,
   input  logic                     rd_en,
   output logic [DATA_W-1:0]        rd_dat,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW:0]       wr_ptr;
   logic [AW:0]       rd_ptr;
   logic              wr_ok;
   logic              rd_ok;

   // A write on a full buffer is dropped even when a pop frees a slot this cycle.
   assign wr_ok = wr_en && !full;
   assign rd_ok = rd_en && !empty;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (rd_ok) rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (wr_ok) mem[wr_ptr[AW-1:0]] <= wr_dat;
   end

   assign level  = wr_ptr - rd_ptr;
   assign full   = (level == (AW+1)'(DEPTH));
   assign empty  = (wr_ptr == rd_ptr);
   assign rd_dat = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/burst_stream_tx.sv
// Buffers host samples and, on start, drains them as val-qualified bursts of bl samples
// separated by gl idle cycles; dat_o/val_o/done are registered.
module burst_stream_tx
   import burst_stream_tx_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH  = 16,
   parameter int LEN_W  = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] wr_dat,
   input  logic              wr_en,
   output logic              full,
   output logic [LEN_W-1:0]  level,
   output logic              overflow,
   input  logic              start,
   input  logic [LEN_W-1:0]  burst_len,
   input  logic [LEN_W-1:0]  gap_len,
   output logic [DATA_W-1:0] dat_o,
   output logic              val_o,
   output logic              busy,
   output logic              done
);

   localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

   state_t                 state_q, state_d;
   logic [LEN_W-1:0]       bl_q, bl_d;
   logic [LEN_W-1:0]       gl_q, gl_d;
   logic [LEN_W-1:0]       cnt_q, cnt_d;
   logic [LEN_W-1:0]       gcnt_q, gcnt_d;
   logic [DATA_W-1:0]      dat_d;
   logic                   val_d;
   logic                   done_d;
   logic                   rd_en;
   logic [DATA_W-1:0]      rd_dat;
   logic                   empty;
   logic [$clog2(DEPTH):0] fifo_level;

   function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
      return (len == '0) ? ONE : len;
   endfunction

   sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk    (clk),
      .rst_n  (rst_n),
      .wr_en  (wr_en),
      .wr_dat (wr_dat),
      .rd_en  (rd_en),
      .rd_dat (rd_dat),
      .full   (full),
      .empty  (empty),
      .level  (fifo_level)
   );

   assign level = LEN_W'(fifo_level);
   assign busy  = (state_q != IDLE);

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      bl_d    = bl_q;
      gl_d    = gl_q;
      cnt_d   = cnt_q;
      gcnt_d  = gcnt_q;
      dat_d   = dat_o;
      val_d   = 1'b0;
      done_d  = 1'b0;
      rd_en   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               bl_d   = clamp_len(burst_len);
               gl_d   = gap_len;
               cnt_d  = '0;
               gcnt_d = '0;
               if (!empty) state_d = BURST;
               else        done_d  = 1'b1;
            end
         end
         BURST: begin
            // Running dry ends the drain, even partway through a burst.
            if (empty) begin
               done_d  = 1'b1;
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               rd_en = 1'b1;
               dat_d = rd_dat;
               val_d = 1'b1;
               if (cnt_q + ONE == bl_q) begin
                  cnt_d = '0;
                  if (gl_q != '0) begin
                     gcnt_d  = '0;
                     state_d = GAP;
                  end
               end else begin
                  cnt_d = cnt_q + ONE;
               end
            end
         end
         GAP: begin
            if (gcnt_q + ONE == gl_q) begin
               gcnt_d = '0;
               if (empty) begin
                  done_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  state_d = BURST;
               end
            end else begin
               gcnt_d = gcnt_q + ONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bl_q     <= ONE;
         gl_q     <= '0;
         cnt_q    <= '0;
         gcnt_q   <= '0;
         dat_o    <= '0;
         val_o    <= 1'b0;
         done     <= 1'b0;
         overflow <= 1'b0;
      end else begin
         bl_q     <= bl_d;
         gl_q     <= gl_d;
         cnt_q    <= cnt_d;
         gcnt_q   <= gcnt_d;
         dat_o    <= dat_d;
         val_o    <= val_d;
         done     <= done_d;
         overflow <= overflow | (wr_en & full);
      end
   end

endmodule

// File: tb/tb_burst_stream_tx.sv
// Randomized bench for burst_stream_tx: a queue scoreboard tracks buffered samples and
// drain val/done patterns are derived from sample count, burst and gap lengths.
module tb_burst_stream_tx;

   localparam int DATA_W = 8;
   localparam int DEPTH  = 16;
   localparam int LEN_W  = 5;

   logic              clk;
   logic              rst_n;
   logic [DATA_W-1:0] wr_dat;
   logic              wr_en;
   logic              full;
   logic [LEN_W-1:0]  level;
   logic              overflow;
   logic              start;
   logic [LEN_W-1:0]  burst_len;
   logic [LEN_W-1:0]  gap_len;
   logic [DATA_W-1:0] dat_o;
   logic              val_o;
   logic              busy;
   logic              done;

   int n_chk  = 0;
   int n_fail = 0;

   logic [DATA_W-1:0] mq [$];
   bit                model_ovf = 1'b0;
   int                pre_size;

   burst_stream_tx #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .LEN_W  (LEN_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_dat    (wr_dat),
      .wr_en     (wr_en),
      .full      (full),
      .level     (level),
      .overflow  (overflow),
      .start     (start),
      .burst_len (burst_len),
      .gap_len   (gap_len),
      .dat_o     (dat_o),
      .val_o     (val_o),
      .busy      (busy),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: accepted writes queue up in order; every val_o pops the oldest one.
   always @(posedge clk) begin
      if (!rst_n) begin
         mq.delete();
         model_ovf = 1'b0;
      end else begin
         pre_size = mq.size();
         if (wr_en) begin
            if (pre_size == DEPTH) model_ovf = 1'b1;
            else                   mq.push_back(wr_dat);
         end
         #1;
         if (pre_size == 0)  chk("val_on_empty", val_o, 0);
         else if (val_o)     chk("dat_order", dat_o, mq.pop_front());
         chk("level", level, mq.size());
         chk("full", full, mq.size() == DEPTH);
         chk("overflow", overflow, model_ovf);
      end
   end

   task automatic push(input logic [DATA_W-1:0] d);
      @(negedge clk);
      wr_en  = 1'b1;
      wr_dat = d;
   endtask

   task automatic idle_in();
      @(negedge clk);
      wr_en = 1'b0;
      start = 1'b0;
   endtask

   // k buffered samples leave as runs of bl with gl low cycles after each full run;
   // done follows the last sample, or ends the trailing gap when the last run was full.
   task automatic run_drain(input int bl, input int gl);
      int k;
      int ble;
      bit ev[$];
      bit ed[$];
      k   = mq.size();
      ble = (bl == 0) ? 1 : bl;
      if (k == 0) begin
         ev.push_back(1'b0); ed.push_back(1'b0);
      end else begin
         for (int j = 0; j < k; j++) begin
            ev.push_back(1'b1); ed.push_back(1'b0);
            if (((j + 1) % ble == 0) && gl > 0)
               for (int g = 1; g <= gl; g++) begin
                  ev.push_back(1'b0);
                  ed.push_back((j == k - 1) && (g == gl));
               end
         end
         if (!((k % ble == 0) && gl > 0)) begin
            ev.push_back(1'b0); ed.push_back(1'b1);
         end
      end
      @(negedge clk);
      start     = 1'b1;
      burst_len = bl[LEN_W-1:0];
      gap_len   = gl[LEN_W-1:0];
      @(posedge clk); #1;
      chk("start_busy", busy, k > 0);
      chk("start_done", done, k == 0);
      chk("start_val", val_o, 0);
      @(negedge clk);
      start = 1'b0;
      foreach (ev[i]) begin
         @(posedge clk); #1;
         chk("drain_val", val_o, ev[i]);
         chk("drain_done", done, ed[i]);
         chk("drain_busy", busy, (k > 0) && !ed[i]);
      end
      chk("drain_end_level", level, 0);
   endtask

   initial begin
      logic [DATA_W-1:0] d [0:10];
      rst_n = 1'b0; wr_en = 1'b0; wr_dat = '0; start = 1'b0; burst_len = '0; gap_len = '0;
      repeat (3) @(negedge clk);
      chk("rst_dat", dat_o, 0);
      chk("rst_val", val_o, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_level", level, 0);
      chk("rst_full", full, 0);
      rst_n = 1'b1;

      // Three samples, one continuous burst.
      push(8'd10); push(8'd20); push(8'd30); idle_in();
      run_drain(3, 0);

      // Seven samples, bursts of 3 with 2-cycle gaps.
      for (int i = 1; i <= 7; i++) push(DATA_W'(i));
      idle_in();
      run_drain(3, 2);

      // Fill, then one dropped write.
      for (int i = 0; i < DEPTH; i++) push(DATA_W'($urandom));
      idle_in();
      chk("t3_full", full, 1);
      push(8'hEE); idle_in();
      chk("t3_ovf", overflow, 1);
      chk("t3_level", level, DEPTH);
      run_drain(5, 1);
      chk("t3_ovf_sticky", overflow, 1);
      chk("t3_not_full", full, 0);

      // Start on an empty buffer.
      run_drain(2, 2);

      // Reset in the middle of the first burst.
      for (int i = 0; i < 8; i++) push(DATA_W'($urandom));
      idle_in();
      @(negedge clk); start = 1'b1; burst_len = 5'd4; gap_len = 5'd3;
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("t5_val_before", val_o, 1);
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("t5_val", val_o, 0);
      chk("t5_level", level, 0);
      chk("t5_busy", busy, 0);
      chk("t5_done", done, 0);
      @(negedge clk); rst_n = 1'b1;

      // bl=0 behaves as 1; writes every cycle keep val_o continuously high.
      for (int i = 0; i <= 10; i++) d[i] = DATA_W'($urandom);
      @(negedge clk); wr_en = 1'b1; wr_dat = d[0];
      @(negedge clk); wr_dat = d[1]; start = 1'b1; burst_len = '0; gap_len = '0;
      @(posedge clk); #1;
      chk("t6_busy", busy, 1);
      for (int i = 2; i <= 10; i++) begin
         @(negedge clk); start = 1'b0; wr_dat = d[i];
         @(posedge clk); #1;
         chk("t6_val", val_o, 1);
      end
      @(negedge clk); wr_en = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
         chk("t6_val_tail", val_o, 1);
      end
      @(posedge clk); #1;
      chk("t6_val_end", val_o, 0);
      chk("t6_done", done, 1);
      @(negedge clk);

      // Random sample counts, burst and gap lengths.
      repeat (6) begin
         int k;
         k = $urandom_range(1, DEPTH);
         for (int i = 0; i < k; i++) push(DATA_W'($urandom));
         idle_in();
         run_drain($urandom_range(0, 6), $urandom_range(0, 3));
      end

      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
